bin_to_bcd_digits: RTL and testbench

Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method. It sits directly upstream of the four-digit multiplexed seven-segment driver. It takes the adder/subtractor result as a signed or unsigned binary value and produces four registered 4-bit digit codes (num_1..num_4). The codes are held stable between conversions, so the display never shows a partially converted value.

---
 rtl/bin_to_bcd_digits_pkg.sv | 18 +
 rtl/bin_to_bcd_digits_if.sv | 33 +++
 rtl/bin_to_bcd_digits_bcd_add3.sv | 14 +
 rtl/bin_to_bcd_digits.sv | 139 +++++++++++++
 tb/tb_bin_to_bcd_digits.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_digits_pkg.sv
// Shared definitions for the binary-to-BCD digit converter.
//   state_e           : converter FSM states
//   DefaultNegCode    : digit code the seven-segment decoder shows as a minus sign
//   DefaultBlankCode  : digit code the decoder shows as all segments off
//   NumDigits         : number of BCD magnitude digits (hundreds, tens, ones)
package bin_to_bcd_digits_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFinish
  } state_e;

  localparam logic [3:0]  DefaultNegCode   = 4'hA;
  localparam logic [3:0]  DefaultBlankCode = 4'hF;
  localparam int unsigned NumDigits        = 3;

endpackage

// File: rtl/bin_to_bcd_digits_if.sv
// Request/result bundle between the arithmetic result source and the converter.
//   start       : one-cycle convert request
//   value       : binary operand, sampled when start is accepted
//   signed_mode : 1 = value is two's complement
//   num_1..num_4: ones, tens, hundreds and sign digit codes
//   busy        : conversion in progress
//   done        : one-cycle pulse when the digit codes update
// master = requester side, slave = converter side.
interface bin_to_bcd_digits_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] value;
  logic             signed_mode;
  logic [3:0]       num_1;
  logic [3:0]       num_2;
  logic [3:0]       num_3;
  logic [3:0]       num_4;
  logic             busy;
  logic             done;

  modport master (
    output start, value, signed_mode,
    input  num_1, num_2, num_3, num_4, busy, done
  );

  modport slave (
    input  start, value, signed_mode,
    output num_1, num_2, num_3, num_4, busy, done
  );

endinterface

// File: rtl/bin_to_bcd_digits_bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
//   digit    : BCD nibble before correction
//   adjusted : corrected nibble
module bin_to_bcd_digits_bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding the four-digit
// seven-segment driver. One magnitude bit is shifted in per clock; the digit
// codes are registered and only change on the done edge or on reset, so the
// display never sees a partial conversion.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   conv  : request/result bundle (slave side), see bin_to_bcd_digits_if
// Parameters: WIDTH (2..9), NEG_CODE, BLANK_CODE, LZB (leading-zero blanking).
module bin_to_bcd_digits
  import bin_to_bcd_digits_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic [3:0]  NEG_CODE   = DefaultNegCode,
  parameter logic [3:0]  BLANK_CODE = DefaultBlankCode,
  parameter bit          LZB        = 1'b1
) (
  input logic                clk,
  input logic                reset,
  bin_to_bcd_digits_if.slave conv
);

  localparam int unsigned BcdW = 4 * NumDigits;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BcdW-1:0]  bcd_q, bcd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       num_1_q, num_1_d;
  logic [3:0]       num_2_q, num_2_d;
  logic [3:0]       num_3_q, num_3_d;
  logic [3:0]       num_4_q, num_4_d;
  logic             done_q, done_d;

  logic [BcdW-1:0]  bcd_adj;
  logic             value_neg;
  logic [WIDTH-1:0] value_mag;
  logic [3:0]       hundreds, tens, ones;

  for (genvar i = 0; i < NumDigits; i++) begin : g_add3
    bin_to_bcd_digits_bcd_add3 u_add3 (
      .digit    (bcd_q[4*i +: 4]),
      .adjusted (bcd_adj[4*i +: 4])
    );
  end

  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits in WIDTH
  // unsigned bits, so the zero-extension bit never needs storing.
  always_comb begin
    value_neg = conv.signed_mode & conv.value[WIDTH-1];
    value_mag = value_neg ? (~conv.value + WIDTH'(1)) : conv.value;
  end

  assign hundreds = bcd_q[11:8];
  assign tens     = bcd_q[7:4];
  assign ones     = bcd_q[3:0];

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    num_1_d = num_1_q;
    num_2_d = num_2_q;
    num_3_d = num_3_q;
    num_4_d = num_4_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (conv.start) begin
          neg_d   = value_neg;
          mag_d   = value_mag;
          bcd_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StShift;
        end
      end

      StShift: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d          = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFinish;
        end
      end

      StFinish: begin
        num_1_d = ones;
        num_2_d = (LZB && hundreds == 4'd0 && tens == 4'd0) ? BLANK_CODE : tens;
        num_3_d = (LZB && hundreds == 4'd0) ? BLANK_CODE : hundreds;
        // The sign stays in the leftmost position regardless of blanking.
        num_4_d = neg_q ? NEG_CODE : BLANK_CODE;
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      num_1_q <= 4'h0;
      num_2_q <= BLANK_CODE;
      num_3_q <= BLANK_CODE;
      num_4_q <= BLANK_CODE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      num_1_q <= num_1_d;
      num_2_q <= num_2_d;
      num_3_q <= num_3_d;
      num_4_q <= num_4_d;
      done_q  <= done_d;
    end
  end

  assign conv.num_1 = num_1_q;
  assign conv.num_2 = num_2_q;
  assign conv.num_3 = num_3_q;
  assign conv.num_4 = num_4_q;
  assign conv.busy  = (state_q != StIdle);
  assign conv.done  = done_q;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Bench for bin_to_bcd_digits: two instances (blanking on and off) see identical
// stimulus; results are compared with a decimal-arithmetic reference model.
module tb_bin_to_bcd_digits;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bin_to_bcd_digits_if #(.WIDTH(8)) if_a ();
  bin_to_bcd_digits_if #(.WIDTH(8)) if_b ();

  assign if_b.start       = if_a.start;
  assign if_b.value       = if_a.value;
  assign if_b.signed_mode = if_a.signed_mode;

  bin_to_bcd_digits #(.WIDTH(8), .LZB(1'b1)) u_dut_lzb (
    .clk   (clk),
    .reset (reset),
    .conv  (if_a)
  );

  bin_to_bcd_digits #(.WIDTH(8), .LZB(1'b0)) u_dut_nolzb (
    .clk   (clk),
    .reset (reset),
    .conv  (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [15:0] ResetDigits = 16'hFFF0;

  logic [15:0] exp_a;
  logic [15:0] exp_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Decimal reference: {sign, hundreds, tens, ones} digit codes.
  function automatic logic [15:0] model(input logic [7:0] v, input bit sm, input bit lzb);
    bit         neg;
    int         mag;
    logic [3:0] h, t, o, d3, d2, d4;
    neg = sm && v[7];
    mag = neg ? 256 - int'(v) : int'(v);
    h   = 4'(mag / 100);
    t   = 4'((mag / 10) % 10);
    o   = 4'(mag % 10);
    d3  = (lzb && h == 0) ? 4'hF : h;
    d2  = (lzb && h == 0 && t == 0) ? 4'hF : t;
    d4  = neg ? 4'hA : 4'hF;
    return {d4, d3, d2, d1_pass(o)};
  endfunction

  function automatic logic [3:0] d1_pass(input logic [3:0] o);
    return o;
  endfunction

  function automatic logic [15:0] digits_a();
    return {if_a.num_4, if_a.num_3, if_a.num_2, if_a.num_1};
  endfunction

  function automatic logic [15:0] digits_b();
    return {if_b.num_4, if_b.num_3, if_b.num_2, if_b.num_1};
  endfunction

  // One conversion. inject_at>0 pulses a second start (inj_val) inside the
  // busy window; reset_at>0 asserts reset that many cycles after acceptance.
  task automatic run_conv(input logic [7:0] v, input bit sm, input int inject_at,
                          input logic [7:0] inj_val, input int reset_at);
    int n;
    int got_at;
    int done_cnt;
    bit busy_ok;
    bit stable_ok;
    bit exp_busy;
    @(negedge clk);
    if_a.start       = 1'b1;
    if_a.value       = v;
    if_a.signed_mode = sm;
    @(negedge clk);
    if_a.start       = 1'b0;
    if_a.value       = 8'($urandom);
    if_a.signed_mode = 1'($urandom);
    check_eq("busy_after_accept", 32'(if_a.busy), 32'd1);
    n         = 0;
    got_at    = 0;
    done_cnt  = 0;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (reset_at != 0 && n == reset_at) begin
        reset = 1'b1;
        #1;
        check_eq("rst_mid_digits_a", 32'(digits_a()), 32'(ResetDigits));
        check_eq("rst_mid_digits_b", 32'(digits_b()), 32'(ResetDigits));
        check_eq("rst_mid_busy", 32'(if_a.busy), 32'd0);
        exp_a = ResetDigits;
        exp_b = ResetDigits;
        @(negedge clk);
        reset = 1'b0;
      end else if (if_a.done) begin
        done_cnt++;
        if (got_at == 0) got_at = n;
        exp_a = model(v, sm, 1'b1);
        exp_b = model(v, sm, 1'b0);
        check_eq("digits_lzb1", 32'(digits_a()), 32'(exp_a));
        check_eq("digits_lzb0", 32'(digits_b()), 32'(exp_b));
        check_eq("busy_at_done", 32'(if_a.busy), 32'd0);
      end else begin
        exp_busy  = (got_at == 0) && !(reset_at != 0 && n >= reset_at);
        busy_ok   = busy_ok && (if_a.busy == exp_busy);
        stable_ok = stable_ok && (digits_a() == exp_a) && (digits_b() == exp_b);
      end
      if (inject_at != 0 && n == inject_at) begin
        if_a.start = 1'b1;
        if_a.value = inj_val;
      end else begin
        if_a.start = 1'b0;
      end
    end
    check_eq("busy_profile", 32'(busy_ok), 32'd1);
    check_eq("outputs_stable", 32'(stable_ok), 32'd1);
    if (reset_at != 0) begin
      check_eq("no_done_after_reset", 32'(done_cnt), 32'd0);
    end else begin
      check_eq("done_latency", 32'(got_at), 32'd9);
      check_eq("done_pulse_count", 32'(done_cnt), 32'd1);
    end
  endtask

  initial begin
    int          inj;
    logic [7:0]  rv;
    bit          rs;
    total            = 0;
    bad              = 0;
    reset            = 1'b1;
    if_a.start       = 1'b0;
    if_a.value       = 8'h00;
    if_a.signed_mode = 1'b0;
    exp_a            = ResetDigits;
    exp_b            = ResetDigits;
    #1;
    check_eq("rst_digits_a", 32'(digits_a()), 32'(ResetDigits));
    check_eq("rst_digits_b", 32'(digits_b()), 32'(ResetDigits));
    check_eq("rst_busy", 32'(if_a.busy), 32'd0);
    check_eq("rst_done", 32'(if_a.done), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_conv(8'd37,  1'b1, 0, 8'd0, 0);
    run_conv(8'h80,  1'b1, 0, 8'd0, 0);
    run_conv(8'hFF,  1'b0, 0, 8'd0, 0);
    run_conv(8'hFF,  1'b1, 0, 8'd0, 0);
    run_conv(8'd0,   1'b0, 0, 8'd0, 0);
    run_conv(8'd0,   1'b1, 0, 8'd0, 0);
    run_conv(8'd37,  1'b1, 3, 8'd99, 0);
    run_conv(8'd99,  1'b1, 0, 8'd0, 0);
    run_conv(8'd123, 1'b0, 0, 8'd0, 4);
    run_conv(8'd123, 1'b0, 0, 8'd0, 0);
    run_conv(8'd100, 1'b0, 8, 8'd7, 0);
    run_conv(8'd127, 1'b1, 0, 8'd0, 0);

    for (int i = 0; i < 40; i++) begin
      rv  = 8'($urandom_range(0, 255));
      rs  = 1'($urandom_range(0, 1));
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_conv(rv, rs, inj, 8'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
